// File: rtl/id_ex_hazard_unit.sv
// Hazard/forwarding controller on the consumer side of ID/EX: tracks in-flight
// destinations for MEM and WB, selects ALU operand forwards, raises load-use stalls.
module id_ex_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       idex_rd,
  input  logic             idex_RegWrite,
  input  logic             idex_RegDst,
  input  logic             idex_MemRead,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_count
);

  logic [4:0]       w_ex_dest;
  logic             w_ex_valid;
  logic             w_lu;
  logic             w_stall;
  logic             w_any_fwd;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  logic [4:0]       r_mem_dest;
  logic             r_mem_valid;
  logic             r_mem_load;
  logic [4:0]       r_wb_dest;
  logic             r_wb_valid;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_fwd_count;

  // A load sitting in MEM has no data yet, so it is only ever forwarded from WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mem_dest,
    input logic       mem_valid,
    input logic       mem_load,
    input logic [4:0] wb_dest,
    input logic       wb_valid
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (mem_valid && !mem_load && (mem_dest == src))
        sel = 2'b10;
      else if (wb_valid && (wb_dest == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_ex_dest  = idex_RegDst ? idex_rd : idex_rt;
    w_ex_valid = idex_RegWrite && (w_ex_dest != 5'd0);

    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (rst_n) begin
      w_fwd_a = fwd_sel(idex_rs, r_mem_dest, r_mem_valid, r_mem_load, r_wb_dest, r_wb_valid);
      w_fwd_b = fwd_sel(idex_rt, r_mem_dest, r_mem_valid, r_mem_load, r_wb_dest, r_wb_valid);
    end
    w_any_fwd = (w_fwd_a != 2'b00) || (w_fwd_b != 2'b00);

    w_lu = idex_MemRead && (idex_rt != 5'd0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    // A flushed ID instruction dies anyway, so it never needs to wait.
    w_stall = w_lu && !flush && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_dest    <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_load    <= 1'b0;
      r_wb_dest     <= '0;
      r_wb_valid    <= 1'b0;
      r_stall_count <= '0;
      r_fwd_count   <= '0;
    end else begin
      r_mem_dest  <= w_ex_dest;
      r_mem_valid <= w_ex_valid;
      r_mem_load  <= idex_MemRead;
      r_wb_dest   <= r_mem_dest;
      r_wb_valid  <= r_mem_valid;
      if (w_stall)
        r_stall_count <= sat_inc(r_stall_count);
      if (w_any_fwd)
        r_fwd_count <= sat_inc(r_fwd_count);
    end
  end

  assign forwardA    = w_fwd_a;
  assign forwardB    = w_fwd_b;
  assign stall       = w_stall;
  assign bubble      = w_stall || (flush && rst_n);
  assign stall_count = r_stall_count;
  assign fwd_count   = r_fwd_count;

endmodule

// File: tb/tb_id_ex_hazard_unit.sv
// Scoreboard bench for id_ex_hazard_unit: a history-based reference model queues
// expected outputs per cycle; a negedge monitor pops and compares them.
module tb_id_ex_hazard_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    idex_rs = '0, idex_rt = '0, idex_rd = '0;
  logic          idex_RegWrite = 1'b0, idex_RegDst = 1'b0, idex_MemRead = 1'b0;
  logic [4:0]    ifid_rs = '0, ifid_rt = '0;
  logic          ifid_uses_rt = 1'b0, flush = 1'b0;
  logic [1:0]    forwardA, forwardB;
  logic          stall, bubble;
  logic [CW-1:0] stall_count, fwd_count;

  always #5 clk = ~clk;

  id_ex_hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_RegWrite(idex_RegWrite), .idex_RegDst(idex_RegDst), .idex_MemRead(idex_MemRead),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .flush(flush),
    .forwardA(forwardA), .forwardB(forwardB), .stall(stall), .bubble(bubble),
    .stall_count(stall_count), .fwd_count(fwd_count)
  );

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          st;
    logic          bb;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  // One entry per instruction that left ID/EX since the last reset, newest last.
  typedef struct packed {
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } instr_t;

  exp_t   q[$];
  instr_t hist[$];
  int     m_sc = 0;
  int     m_fc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    instr_t mem, wb;
    if (src == 5'd0) return 2'b00;
    if (hist.size() >= 1) begin
      mem = hist[hist.size()-1];
      if (mem.wr && !mem.ld && mem.dest == src) return 2'b10;
    end
    if (hist.size() >= 2) begin
      wb = hist[hist.size()-2];
      if (wb.wr && wb.dest == src) return 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rw, input logic rdst, input logic mr,
                       input logic [4:0] frs, input logic [4:0] frt, input logic fut,
                       input logic fl, input logic rn);
    exp_t   e;
    instr_t cur;
    logic   lu;
    @(posedge clk);
    #1;
    idex_rs = rs; idex_rt = rt; idex_rd = rd;
    idex_RegWrite = rw; idex_RegDst = rdst; idex_MemRead = mr;
    ifid_rs = frs; ifid_rt = frt; ifid_uses_rt = fut; flush = fl; rst_n = rn;
    cur.dest = rdst ? rd : rt;
    cur.wr   = rw && (cur.dest != 5'd0);
    cur.ld   = mr;
    e.sc = m_sc[CW-1:0];
    e.fc = m_fc[CW-1:0];
    if (!rn) begin
      e.fa = 2'b00; e.fb = 2'b00; e.st = 1'b0; e.bb = 1'b0;
      hist.delete();
      m_sc = 0;
      m_fc = 0;
    end else begin
      e.fa = ref_fwd(rs);
      e.fb = ref_fwd(rt);
      lu   = mr && (rt != 5'd0) && ((rt == frs) || (fut && (rt == frt)));
      e.st = lu && !fl;
      e.bb = e.st || fl;
      if (e.st && m_sc < CMAX) m_sc++;
      if ((e.fa != 2'b00 || e.fb != 2'b00) && m_fc < CMAX) m_fc++;
      hist.push_back(cur);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("forwardA", 32'(forwardA), 32'(e.fa));
      check("forwardB", 32'(forwardB), 32'(e.fb));
      check("stall", 32'(stall), 32'(e.st));
      check("bubble", 32'(bubble), 32'(e.bb));
      check("stall_count", 32'(stall_count), 32'(e.sc));
      check("fwd_count", 32'(fwd_count), 32'(e.fc));
    end
  end

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add $3 then sub rs=3: MEM forward
    drive(1, 2, 3, 1, 1, 0, 3, 0, 1, 0, 1);
    drive(3, 6, 7, 1, 1, 0, 0, 0, 0, 0, 1);
    // writer $3, non-writer, consumer rs=3: WB forward
    drive(1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(8, 9, 10, 0, 1, 0, 0, 0, 0, 0, 1);
    drive(3, 0, 11, 1, 1, 0, 0, 0, 0, 0, 1);
    // two writers to $5, consumer rt=5: MEM priority
    drive(1, 2, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 2, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(6, 5, 12, 1, 1, 0, 0, 0, 0, 0, 1);
    // lw $4 with ID reading rs=4: one stall, bubble, then WB forward
    drive(1, 4, 0, 1, 0, 1, 4, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
    drive(4, 0, 13, 1, 1, 0, 0, 0, 0, 0, 1);
    // $0 guard
    drive(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 14, 1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1);
    // flush during load-use
    drive(1, 7, 0, 1, 0, 1, 7, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset mid-stall, then first instruction after release
    drive(1, 9, 0, 1, 0, 1, 9, 0, 0, 0, 1);
    drive(1, 9, 0, 1, 0, 1, 9, 0, 0, 0, 0);
    drive(9, 9, 15, 1, 1, 0, 0, 0, 0, 0, 1);
    // randomized traffic with small register numbers to force many matches
    for (int i = 0; i < 2000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) != 0));
    end
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
